// File: rtl/img_pkg.sv
// Shared definitions for the grayscale point-operation blocks
// (brightness reduce/increase, threshold, invert).
package img_pkg;

  localparam int PIXEL_W = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

endpackage

// File: rtl/brightness_reduce_if.sv
// Pixel stream bundle for a point-operation stage: source-side pixel/offset
// plus the registered result returned to the sink.
interface brightness_reduce_if #(
  parameter int DATA_W = img_pkg::PIXEL_W
);

  logic [DATA_W-1:0] pixel_in;
  logic              valid_in;
  logic [DATA_W-1:0] brightness_value;
  logic [DATA_W-1:0] pixel_out;
  logic              valid_out;

  modport master (
    output pixel_in, valid_in, brightness_value,
    input  pixel_out, valid_out
  );

  modport slave (
    input  pixel_in, valid_in, brightness_value,
    output pixel_out, valid_out
  );

endinterface

// File: rtl/sat_sub.sv
// Combinational saturating unsigned subtractor: y = max(a - b, 0).
module sat_sub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [W:0] diff;

  // One extra bit keeps the borrow, which selects zero instead of wrapping.
  always_comb begin
    diff = {1'b0, a} - {1'b0, b};
    y    = diff[W] ? '0 : diff[W-1:0];
  end

endmodule

// File: rtl/brightness_reduce.sv
// Streaming brightness reduction: subtract an offset from each valid pixel,
// saturating at zero, with a single registered output stage.
module brightness_reduce
  import img_pkg::*;
#(
  parameter int DATA_W = PIXEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] brightness_value,
  output logic [DATA_W-1:0] pixel_out,
  output logic              valid_out
);

  logic [DATA_W-1:0] sub_y;
  logic [DATA_W-1:0] pixel_out_d, pixel_out_q;
  logic              valid_out_d, valid_out_q;

  sat_sub #(.W(DATA_W)) u_sat_sub (
    .a (pixel_in),
    .b (brightness_value),
    .y (sub_y)
  );

  // Hold on idle cycles so garbage on pixel_in never reaches the output.
  always_comb begin
    pixel_out_d = valid_in ? sub_y : pixel_out_q;
    valid_out_d = valid_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_out_q <= '0;
      valid_out_q <= 1'b0;
    end else begin
      pixel_out_q <= pixel_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign pixel_out = pixel_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_brightness_reduce.sv
// Directed bench for brightness_reduce: reset, stream, saturation, gaps,
// pass-through/max offset and an asynchronous mid-frame reset.
module tb_brightness_reduce;
  import img_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  brightness_reduce_if #(.DATA_W(PIXEL_W)) bus ();

  brightness_reduce #(.DATA_W(PIXEL_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .pixel_in         (bus.pixel_in),
    .valid_in         (bus.valid_in),
    .brightness_value (bus.brightness_value),
    .pixel_out        (bus.pixel_out),
    .valid_out        (bus.valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input pixel_t exp_pix, input logic exp_vld);
    vectors++;
    assert (bus.pixel_out === exp_pix)
    else begin
      miscompares++;
      $error("FAIL %s pixel_out: got %0d expected %0d", tag, bus.pixel_out, exp_pix);
    end
    vectors++;
    assert (bus.valid_out === exp_vld)
    else begin
      miscompares++;
      $error("FAIL %s valid_out: got %0b expected %0b", tag, bus.valid_out, exp_vld);
    end
  endtask

  task automatic drive(input pixel_t pix, input logic vld, input pixel_t bv);
    bus.pixel_in         = pix;
    bus.valid_in         = vld;
    bus.brightness_value = bv;
  endtask

  function automatic pixel_t ref_sub(input int p, input int b);
    return (p > b) ? pixel_t'(p - b) : pixel_t'(0);
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset held with a valid pixel presented
    rst = 1'b0;
    drive(8'hFF, 1'b1, 8'd0);
    #1;
    check("reset_t0", 8'd0, 1'b0);
    step();
    check("reset_edge1", 8'd0, 1'b0);
    step();
    check("reset_edge2", 8'd0, 1'b0);

    // Release and stream with offset 50
    rst = 1'b1;
    drive(8'd200, 1'b1, 8'd50);
    step();
    check("stream_200", 8'd150, 1'b1);
    drive(8'd100, 1'b1, 8'd50);
    step();
    check("stream_100", 8'd50, 1'b1);
    drive(8'd51, 1'b1, 8'd50);
    step();
    check("stream_51", 8'd1, 1'b1);

    // Saturation, no wrap
    drive(8'd30, 1'b1, 8'd50);
    step();
    check("sat_30", 8'd0, 1'b1);
    drive(8'd200, 1'b1, 8'd50);
    step();
    check("restore_200", 8'd150, 1'b1);
    drive(8'd50, 1'b1, 8'd50);
    step();
    check("sat_equal", 8'd0, 1'b1);
    drive(8'd0, 1'b1, 8'd50);
    step();
    check("sat_zero", 8'd0, 1'b1);

    // Pass-through and maximum offset
    drive(8'hAB, 1'b1, 8'd0);
    step();
    check("pass_AB", 8'hAB, 1'b1);
    drive(8'hFF, 1'b1, 8'd255);
    step();
    check("max_FF", 8'd0, 1'b1);
    drive(8'hFE, 1'b1, 8'd1);
    step();
    check("off1_FE", 8'hFD, 1'b1);
    drive(8'h80, 1'b1, 8'd255);
    step();
    check("max_80", 8'd0, 1'b1);

    // Gaps with X on data/offset while idle
    drive(8'd120, 1'b1, 8'd20);
    step();
    check("gap_120", 8'd100, 1'b1);
    bus.pixel_in         = 'x;
    bus.valid_in         = 1'b0;
    bus.brightness_value = 'x;
    step();
    check("gap_idle1", 8'd100, 1'b0);
    step();
    check("gap_idle2", 8'd100, 1'b0);
    drive(8'd90, 1'b1, 8'd20);
    #1;
    check("no_comb_path", 8'd100, 1'b0);
    step();
    check("gap_90", 8'd70, 1'b1);

    // 8x8 frame with an asynchronous reset between edges
    for (int i = 0; i < 20; i++) begin
      drive(pixel_t'(i * 4), 1'b1, 8'd50);
      step();
      check($sformatf("frame_px%0d", i), ref_sub(i * 4, 50), 1'b1);
    end
    #2;
    rst = 1'b0;
    #1;
    check("midreset_async", 8'd0, 1'b0);
    drive(pixel_t'(20 * 4), 1'b1, 8'd50);
    step();
    check("midreset_hold", 8'd0, 1'b0);
    drive(pixel_t'(21 * 4), 1'b1, 8'd50);
    step();
    check("midreset_hold2", 8'd0, 1'b0);
    rst = 1'b1;
    bus.valid_in = 1'b0;
    #1;
    check("release_no_spurious", 8'd0, 1'b0);
    step();
    check("release_idle_edge", 8'd0, 1'b0);
    for (int i = 22; i < 64; i++) begin
      drive(pixel_t'(i * 4), 1'b1, 8'd50);
      step();
      check($sformatf("frame_px%0d", i), ref_sub(i * 4, 50), 1'b1);
    end
    bus.valid_in = 1'b0;
    step();
    check("frame_end_hold", ref_sub(63 * 4, 50), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
